// File: rtl/axis_incr_pkt_checker.sv
// rtl/axis_incr_pkt_checker.sv - AXI-Stream incrementing-pattern packet checker
// Counts packets, classifies data/early/late tlast errors, optional LFSR backpressure.
module axis_incr_pkt_checker #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      cfg_len,
  input  logic             bp_en,
  input  logic [DSIZE-1:0] axis_tdata,
  input  logic             axis_tvalid,
  input  logic             axis_tlast,
  output logic             axis_tready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       err_code,
  output logic             pkt_done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

  localparam logic [1:0]  E_NONE    = 2'd0;
  localparam logic [1:0]  E_DATA    = 2'd1;
  localparam logic [1:0]  E_EARLY   = 2'd2;
  localparam logic [1:0]  E_LATE    = 2'd3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Error codes are ordered so the numerically larger code wins.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_int_n;
  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [DSIZE-1:0] exp_q, exp_d;
  logic [15:0]      beat_idx_q, beat_idx_d;
  logic [1:0]       pkt_err_q, pkt_err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             pkt_done_q, pkt_done_d;
  logic             busy_q, busy_d;
  logic [15:0]      lfsr_q, lfsr_d;

  logic             lfsr_fb;
  logic             accept;
  logic             data_err;
  logic [16:0]      idx_next;
  logic [16:0]      len_ext;
  logic [1:0]       cur_code;
  logic [1:0]       end_code;
  logic             pkt_end;

  // Assertion is asynchronous; release reaches the logic two clocks later.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign axis_tready = rst_int_n & enable & (~bp_en | lfsr_q[0]);
  assign accept      = axis_tvalid & axis_tready;
  assign data_err    = (axis_tdata != exp_q);
  assign idx_next    = {1'b0, beat_idx_q} + 17'd1;
  assign len_ext     = {1'b0, len_q};

  always_comb begin
    lfsr_d     = bp_en ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
    state_d    = state_q;
    len_d      = len_q;
    exp_d      = exp_q;
    beat_idx_d = beat_idx_q;
    pkt_err_d  = pkt_err_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_code_d = err_code_q;
    busy_d     = busy_q;
    pkt_done_d = 1'b0;
    pkt_end    = 1'b0;
    cur_code   = pkt_err_q;
    end_code   = pkt_err_q;

    if (accept) begin
      case (state_q)
        IDLE: begin
          len_d      = cfg_len;
          exp_d      = axis_tdata + DSIZE'(1);
          beat_idx_d = 16'd1;
          busy_d     = 1'b1;
          pkt_err_d  = E_NONE;
          if (axis_tlast) begin
            pkt_end  = 1'b1;
            end_code = (cfg_len == 16'd1) ? E_NONE : E_EARLY;
          end else if (cfg_len <= 16'd1) begin
            // The single expected beat arrived without tlast.
            pkt_err_d = E_LATE;
            state_d   = FLUSH;
          end else begin
            state_d = RECV;
          end
        end
        RECV: begin
          exp_d      = exp_q + DSIZE'(1);
          beat_idx_d = idx_next[15:0];
          cur_code   = worst(pkt_err_q, data_err ? E_DATA : E_NONE);
          if (axis_tlast) begin
            pkt_end  = 1'b1;
            end_code = (idx_next < len_ext) ? worst(cur_code, E_EARLY) : cur_code;
            state_d  = IDLE;
          end else if (idx_next >= len_ext) begin
            pkt_err_d = worst(cur_code, E_LATE);
            state_d   = FLUSH;
          end else begin
            pkt_err_d = cur_code;
          end
        end
        FLUSH: begin
          if (axis_tlast) begin
            pkt_end = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (pkt_end) begin
      busy_d     = 1'b0;
      pkt_done_d = 1'b1;
      pkt_cnt_d  = (&pkt_cnt_q) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
      if (end_code != E_NONE) begin
        err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
        err_code_d = end_code;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      exp_q      <= '0;
      beat_idx_q <= 16'd0;
      pkt_err_q  <= E_NONE;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_code_q <= E_NONE;
      pkt_done_q <= 1'b0;
      busy_q     <= 1'b0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      exp_q      <= exp_d;
      beat_idx_q <= beat_idx_d;
      pkt_err_q  <= pkt_err_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_code_q <= err_code_d;
      pkt_done_q <= pkt_done_d;
      busy_q     <= busy_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_code = err_code_q;
  assign pkt_done = pkt_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axis_incr_pkt_checker.sv
// tb/tb_axis_incr_pkt_checker.sv - scoreboard bench for axis_incr_pkt_checker
// A second instance with 4-bit counters shares all inputs for saturation checks.
module tb_axis_incr_pkt_checker;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] cfg_len = 16'd4;
  logic        bp_en = 1'b0;
  logic [7:0]  axis_tdata = 8'd0;
  logic        axis_tvalid = 1'b0;
  logic        axis_tlast = 1'b0;

  logic        axis_tready, pkt_done, busy;
  logic [15:0] pkt_cnt, err_cnt;
  logic [1:0]  err_code;
  logic        tready_s, pkt_done_s, busy_s;
  logic [3:0]  pkt_cnt_s, err_cnt_s;
  logic [1:0]  err_code_s;

  always #5 clock = ~clock;

  axis_incr_pkt_checker #(.DSIZE(8), .CNT_W(16)) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .cfg_len(cfg_len), .bp_en(bp_en),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
    .axis_tready(axis_tready), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
    .err_code(err_code), .pkt_done(pkt_done), .busy(busy)
  );

  axis_incr_pkt_checker #(.DSIZE(8), .CNT_W(4)) dut_sat (
    .clock(clock), .rst_n(rst_n), .enable(enable), .cfg_len(cfg_len), .bp_en(bp_en),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
    .axis_tready(tready_s), .pkt_cnt(pkt_cnt_s), .err_cnt(err_cnt_s),
    .err_code(err_code_s), .pkt_done(pkt_done_s), .busy(busy_s)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] sb[$];
  int         exp_pkt = 0;
  int         exp_err = 0;
  logic [1:0] exp_code = 2'd0;
  int         done_seen = 0;
  int         toggles = 0;
  logic       prev_tready = 1'b0;
  logic [7:0] pkt_d[0:63];
  logic [1:0] sync_m;
  logic [15:0] lfsr_m;

  // Reference for reset release timing and the backpressure sequence.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) sync_m <= 2'b00;
    else        sync_m <= {sync_m[0], 1'b1};
  end

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n)          lfsr_m <= 16'hACE1;
    else if (!sync_m[1]) lfsr_m <= 16'hACE1;
    else if (bp_en)      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  // Scoreboard: each pkt_done retires the oldest queued packet outcome.
  initial begin
    logic [1:0] code_m;
    logic [3:0] pkt_s_m, err_s_m;
    forever begin
      @(negedge clock);
      if (pkt_done === 1'b1) begin
        done_seen++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_underflow: pkt_done=1 with no packet queued");
        end else begin
          code_m = sb.pop_front();
          if (exp_pkt < 65535) exp_pkt++;
          if (code_m != 2'd0) begin
            if (exp_err < 65535) exp_err++;
            exp_code = code_m;
          end
          if (pkt_cnt !== 16'(exp_pkt) || err_cnt !== 16'(exp_err) || err_code !== exp_code) begin
            miscompares++;
            $display("FAIL sb_counts: got pkt=%0d err=%0d code=%0d, want pkt=%0d err=%0d code=%0d",
                     pkt_cnt, err_cnt, err_code, exp_pkt, exp_err, exp_code);
          end
          pkt_s_m = (exp_pkt > 15) ? 4'hF : 4'(exp_pkt);
          err_s_m = (exp_err > 15) ? 4'hF : 4'(exp_err);
          vectors++;
          if (pkt_cnt_s !== pkt_s_m || err_cnt_s !== err_s_m || err_code_s !== exp_code || pkt_done_s !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_sat_counts: got pkt=%0d err=%0d code=%0d done=%b, want pkt=%0d err=%0d code=%0d done=1",
                     pkt_cnt_s, err_cnt_s, err_code_s, pkt_done_s, pkt_s_m, err_s_m, exp_code);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int   n;
    logic acc;
    axis_tdata  = d;
    axis_tlast  = l;
    axis_tvalid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      #1;
      vectors++;
      if (axis_tready !== (enable & sync_m[1] & (~bp_en | lfsr_m[0]))) begin
        miscompares++;
        $display("FAIL tready: got %b want %b", axis_tready, enable & sync_m[1] & (~bp_en | lfsr_m[0]));
      end
      if (axis_tready !== prev_tready) toggles++;
      prev_tready = axis_tready;
      acc = axis_tready;
      @(negedge clock);
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: tready=0 for %0d cycles, want acceptance", n);
    end
  endtask

  task automatic send_pkt(input int n, input logic [1:0] code);
    sb.push_back(code);
    for (int i = 0; i < n; i++) begin
      send_beat(pkt_d[i], (i == n - 1));
      vectors++;
      if (busy !== (i != n - 1)) begin
        miscompares++;
        $display("FAIL busy_beat%0d: got %b want %b", i, busy, (i != n - 1));
      end
    end
  endtask

  task automatic fill_incr(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) pkt_d[i] = start + 8'(i);
  endtask

  task automatic idle(input int k);
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
    repeat (k) @(negedge clock);
  endtask

  task automatic do_reset;
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
    bp_en       = 1'b0;
    enable      = 1'b1;
    rst_n       = 1'b0;
    #1;
    sb.delete();
    exp_pkt = 0; exp_err = 0; exp_code = 2'd0; done_seen = 0;
    @(negedge clock);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({axis_tready, pkt_cnt, err_cnt, err_code, pkt_done, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got tready=%b pkt=%0d err=%0d code=%0d done=%b busy=%b, want all 0",
               axis_tready, pkt_cnt, err_cnt, err_code, pkt_done, busy);
    end
    vectors++;
    if ({tready_s, pkt_cnt_s, err_cnt_s, err_code_s, pkt_done_s, busy_s} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_sat: got nonzero outputs, want all 0");
    end
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sync_0: got tready=%b want 0", axis_tready);
    end
    @(negedge clock);
    vectors++;
    if (axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sync_1: got tready=%b want 0", axis_tready);
    end
    @(negedge clock);
    vectors++;
    if (axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_sync_2: got tready=%b want 1", axis_tready);
    end
  endtask

  task automatic test_clean;
    do_reset();
    cfg_len = 16'd4;
    fill_incr(8'h10, 4);
    send_pkt(4, 2'd0);
    fill_incr(8'hFE, 4);
    send_pkt(4, 2'd0);
    idle(3);
    vectors++;
    if (pkt_cnt !== 16'd2 || err_cnt !== 16'd0 || done_seen != 2 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL clean: got pkt=%0d err=%0d dones=%0d left=%0d, want 2 0 2 0",
               pkt_cnt, err_cnt, done_seen, sb.size());
    end
  endtask

  task automatic test_data_err;
    do_reset();
    cfg_len = 16'd4;
    pkt_d[0] = 8'h00; pkt_d[1] = 8'h01; pkt_d[2] = 8'h05; pkt_d[3] = 8'h03;
    send_pkt(4, 2'd1);
    idle(3);
    vectors++;
    if (pkt_cnt !== 16'd1 || err_cnt !== 16'd1 || err_code !== 2'd1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL data_err: got pkt=%0d err=%0d code=%0d, want 1 1 1", pkt_cnt, err_cnt, err_code);
    end
  endtask

  task automatic test_early_late;
    do_reset();
    cfg_len = 16'd4;
    pkt_d[0] = 8'h20; pkt_d[1] = 8'h21;
    send_pkt(2, 2'd2);
    cfg_len = 16'd3;
    pkt_d[0] = 8'h30; pkt_d[1] = 8'h31; pkt_d[2] = 8'h32; pkt_d[3] = 8'h77; pkt_d[4] = 8'h88;
    send_pkt(5, 2'd3);
    idle(3);
    vectors++;
    if (pkt_cnt !== 16'd2 || err_cnt !== 16'd2 || err_code !== 2'd3 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL early_late: got pkt=%0d err=%0d code=%0d, want 2 2 3", pkt_cnt, err_cnt, err_code);
    end
  endtask

  task automatic test_stall_cfg_change;
    do_reset();
    cfg_len = 16'd6;
    fill_incr(8'h50, 6);
    sb.push_back(2'd0);
    send_beat(pkt_d[0], 1'b0);
    send_beat(pkt_d[1], 1'b0);
    enable     = 1'b0;
    cfg_len    = 16'd3;
    axis_tdata = pkt_d[2];
    repeat (4) begin
      #1;
      vectors++;
      if (axis_tready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL stall: got tready=%b busy=%b, want 0 1", axis_tready, busy);
      end
      @(negedge clock);
    end
    enable = 1'b1;
    for (int i = 2; i < 6; i++) send_beat(pkt_d[i], (i == 5));
    idle(3);
    vectors++;
    if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL stall_result: got pkt=%0d err=%0d, want 1 0", pkt_cnt, err_cnt);
    end
  endtask

  task automatic test_single_beat;
    do_reset();
    cfg_len  = 16'd1;
    pkt_d[0] = 8'h7E;
    send_pkt(1, 2'd0);
    cfg_len  = 16'd4;
    pkt_d[0] = 8'h11;
    send_pkt(1, 2'd2);
    idle(3);
    vectors++;
    if (pkt_cnt !== 16'd2 || err_cnt !== 16'd1 || err_code !== 2'd2 || done_seen != 2) begin
      miscompares++;
      $display("FAIL single_beat: got pkt=%0d err=%0d code=%0d dones=%0d, want 2 1 2 2",
               pkt_cnt, err_cnt, err_code, done_seen);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    cfg_len = 16'd16;
    bp_en   = 1'b1;
    toggles = 0;
    prev_tready = axis_tready;
    for (int p = 0; p < 100; p++) begin
      fill_incr(8'(p * 16 + 3), 16);
      send_pkt(16, 2'd0);
    end
    idle(3);
    bp_en = 1'b0;
    vectors++;
    if (pkt_cnt !== 16'd100 || err_cnt !== 16'd0 || done_seen != 100 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL backpressure: got pkt=%0d err=%0d dones=%0d, want 100 0 100", pkt_cnt, err_cnt, done_seen);
    end
    vectors++;
    if (toggles < 1) begin
      miscompares++;
      $display("FAIL bp_toggle: got %0d tready toggles, want >= 1", toggles);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    cfg_len = 16'd8;
    fill_incr(8'h00, 8);
    send_pkt(8, 2'd0);
    fill_incr(8'h80, 3);
    for (int i = 0; i < 3; i++) send_beat(pkt_d[i], 1'b0);
    axis_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({axis_tready, pkt_cnt, err_cnt, err_code, pkt_done, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got tready=%b pkt=%0d err=%0d code=%0d done=%b busy=%b, want all 0",
               axis_tready, pkt_cnt, err_cnt, err_code, pkt_done, busy);
    end
    sb.delete();
    exp_pkt = 0; exp_err = 0; exp_code = 2'd0; done_seen = 0;
    @(negedge clock);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    fill_incr(8'h40, 8);
    send_pkt(8, 2'd0);
    idle(3);
    vectors++;
    if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0 || done_seen != 1) begin
      miscompares++;
      $display("FAIL reset_mid_after: got pkt=%0d err=%0d dones=%0d, want 1 0 1", pkt_cnt, err_cnt, done_seen);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    cfg_len = 16'd2;
    for (int k = 0; k < 20; k++) begin
      pkt_d[0] = 8'(k);
      send_pkt(1, 2'd2);
    end
    idle(3);
    vectors++;
    if (err_cnt_s !== 4'hF || pkt_cnt_s !== 4'hF) begin
      miscompares++;
      $display("FAIL saturation: got pkt_s=%0h err_s=%0h, want f f", pkt_cnt_s, err_cnt_s);
    end
    vectors++;
    if (err_cnt !== 16'd20 || pkt_cnt !== 16'd20 || err_code !== 2'd2) begin
      miscompares++;
      $display("FAIL saturation_wide: got pkt=%0d err=%0d code=%0d, want 20 20 2", pkt_cnt, err_cnt, err_code);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_data_err();
    test_early_late();
    test_stall_cfg_change();
    test_single_beat();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
